// File: rtl/crouchpunch_sprite_fetch.sv
// Crouch-punch sprite fetch: attack animation FSM, mirrored sprite ROM addressing,
// and a fixed three-cycle pixel pipeline that delivers a colour index with index-0 transparency.
module crouchpunch_sprite_fetch #(
   parameter int SPR_W         = 64,
   parameter int SPR_H         = 64,
   parameter int FRAMES        = 3,
   parameter int FRAME_TICKS   = 6,
   parameter int RECOVER_TICKS = 8,
   parameter int ADDR_W        = 14
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              vsync_tick,
   input  logic              punch_req,
   input  logic              facing_left,
   input  logic [9:0]        spr_x,
   input  logic [9:0]        spr_y,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              pix_valid,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [3:0]        rom_q,
   output logic [3:0]        pal_index,
   output logic              sprite_on,
   output logic              out_valid,
   output logic              busy,
   output logic [1:0]        anim_frame
);

   // state   | meaning
   // IDLE    | waiting for a latched punch edge; frame 0 shown
   // PLAY    | stepping frames 0..FRAMES-1, FRAME_TICKS vsync ticks each
   // RECOVER | last frame held for RECOVER_TICKS ticks, punches ignored
   typedef enum logic [1:0] {IDLE, PLAY, RECOVER} state_t;

   localparam int TMAX  = (FRAME_TICKS > RECOVER_TICKS) ? FRAME_TICKS : RECOVER_TICKS;
   localparam int CNT_W = $clog2(TMAX + 1);
   localparam int COL_W = $clog2(SPR_W);

   state_t            state_q, state_d;
   logic [1:0]        frame_q, frame_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic              face_q, face_d;
   logic              punch_q;
   logic              punch_rise;

   assign punch_rise = punch_req && !punch_q;

   // punch_q resets high so a button held through reset is not seen as a fresh press
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         frame_q <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         face_q  <= 1'b0;
         punch_q <= 1'b1;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         face_q  <= face_d;
         punch_q <= punch_req;
      end
   end

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      face_d  = face_q;
      if (vsync_tick) face_d = facing_left;
      case (state_q)
         IDLE: begin
            frame_d = '0;
            if (punch_rise) pend_d = 1'b1;
            if (vsync_tick && pend_q) begin
               state_d = PLAY;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end
         end
         PLAY: begin
            if (vsync_tick) begin
               if (cnt_q == CNT_W'(FRAME_TICKS - 1)) begin
                  cnt_d = '0;
                  if (frame_q == 2'(FRAMES - 1)) state_d = RECOVER;
                  else                           frame_d = frame_q + 2'd1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RECOVER: begin
            if (vsync_tick) begin
               if (cnt_q == CNT_W'(RECOVER_TICKS - 1)) begin
                  state_d = IDLE;
                  frame_d = '0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy       = (state_q != IDLE);
   assign anim_frame = frame_q;

   logic [10:0]       x_ext, y_ext, sx_ext, sy_ext, dy;
   logic [COL_W-1:0]  dx_col, col;
   logic              in_box;
   logic [ADDR_W-1:0] addr_d;

   assign x_ext  = {1'b0, DrawX};
   assign y_ext  = {1'b0, DrawY};
   assign sx_ext = {1'b0, spr_x};
   assign sy_ext = {1'b0, spr_y};
   assign dy     = y_ext - sy_ext;
   // only the low column bits of dx are ever used inside the box
   assign dx_col = DrawX[COL_W-1:0] - spr_x[COL_W-1:0];
   assign col    = face_q ? ~dx_col : dx_col;

   assign in_box = pix_valid
                && (x_ext >= sx_ext) && (x_ext < sx_ext + 11'(SPR_W))
                && (y_ext >= sy_ext) && (y_ext < sy_ext + 11'(SPR_H));

   assign addr_d = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H)
                 + ADDR_W'(dy) * ADDR_W'(SPR_W)
                 + ADDR_W'(col);

   logic [ADDR_W-1:0] addr_q;
   logic              box1_q, box2_q, vld1_q, vld2_q;
   logic [3:0]        pal_q, pal_d;
   logic              on_q, on_d, ov_q;

   assign on_d  = box2_q && (rom_q != 4'd0);
   assign pal_d = on_d ? rom_q : 4'd0;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         addr_q <= '0;
         box1_q <= 1'b0;
         box2_q <= 1'b0;
         vld1_q <= 1'b0;
         vld2_q <= 1'b0;
         pal_q  <= '0;
         on_q   <= 1'b0;
         ov_q   <= 1'b0;
      end else begin
         if (in_box) addr_q <= addr_d;
         box1_q <= in_box;
         box2_q <= box1_q;
         vld1_q <= pix_valid;
         vld2_q <= vld1_q;
         pal_q  <= pal_d;
         on_q   <= on_d;
         ov_q   <= vld2_q;
      end
   end

   assign rom_addr  = addr_q;
   assign pal_index = pal_q;
   assign sprite_on = on_q;
   assign out_valid = ov_q;

endmodule

// File: tb/tb_crouchpunch_sprite_fetch.sv
// Directed bench for crouchpunch_sprite_fetch: pixel-path vector table plus hand-written
// animation, reset and raster sequences against a small synchronous ROM model.
module tb_crouchpunch_sprite_fetch;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        vsync_tick, punch_req, facing_left, pix_valid;
   logic [9:0]  spr_x, spr_y, DrawX, DrawY;
   logic [13:0] rom_addr;
   logic [3:0]  rom_q;
   logic [3:0]  pal_index;
   logic        sprite_on, out_valid, busy;
   logic [1:0]  anim_frame;
   logic        rom_zero;

   int total = 0;
   int pass  = 0;

   crouchpunch_sprite_fetch dut (
      .Clk(Clk), .Reset_n(Reset_n), .vsync_tick(vsync_tick), .punch_req(punch_req),
      .facing_left(facing_left), .spr_x(spr_x), .spr_y(spr_y), .DrawX(DrawX), .DrawY(DrawY),
      .pix_valid(pix_valid), .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
      .sprite_on(sprite_on), .out_valid(out_valid), .busy(busy), .anim_frame(anim_frame)
   );

   always #5 Clk = ~Clk;

   function automatic logic [3:0] romf(input logic [13:0] a);
      return a[3:0] ^ {2'b00, a[13:12]};
   endfunction

   always @(posedge Clk) rom_q <= rom_zero ? 4'd0 : romf(rom_addr);

   typedef struct {
      logic [9:0]  sx, sy, x, y;
      logic        v, face, zero;
      logic [13:0] addr;
      logic        on;
      logic [3:0]  idx;
      logic        ov;
   } vec_t;

   vec_t vecs[11];

   function automatic vec_t mk(input int sx, sy, x, y, v, face, zero, addr, on, idx, ov);
      vec_t r;
      r.sx = 10'(sx); r.sy = 10'(sy); r.x = 10'(x); r.y = 10'(y);
      r.v = 1'(v); r.face = 1'(face); r.zero = 1'(zero);
      r.addr = 14'(addr); r.on = 1'(on); r.idx = 4'(idx); r.ov = 1'(ov);
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic tick();
      vsync_tick = 1'b1; step();
      vsync_tick = 1'b0; step(); step();
   endtask

   task automatic punch_edge();
      punch_req = 1'b1; step();
      punch_req = 1'b0; step();
   endtask

   task automatic pixel(input int sx, sy, x, y);
      spr_x = 10'(sx); spr_y = 10'(sy); DrawX = 10'(x); DrawY = 10'(y);
      pix_valid = 1'b1; step();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] pat;
      int          ef, eb;

      Reset_n = 1'b0; vsync_tick = 0; punch_req = 0; facing_left = 0; pix_valid = 0;
      spr_x = 0; spr_y = 0; DrawX = 0; DrawY = 0; rom_zero = 0;

      //       sx    sy   x     y    v f z  addr  on idx ov
      vecs[0]  = mk(100, 200, 105, 203, 1,0,0, 197,  1, 5,  1);
      vecs[1]  = mk(100, 200, 105, 203, 1,0,1, 197,  0, 0,  1);
      vecs[2]  = mk(100, 200, 105, 203, 1,1,0, 250,  1, 10, 1);
      vecs[3]  = mk(100, 200, 164, 203, 1,0,0, 250,  0, 0,  1);
      vecs[4]  = mk(100, 200, 163, 203, 1,0,0, 255,  1, 15, 1);
      vecs[5]  = mk(1000,200, 1023,203, 1,0,0, 215,  1, 7,  1);
      vecs[6]  = mk(1000,200, 999, 203, 1,0,0, 215,  0, 0,  1);
      vecs[7]  = mk(100, 200, 101, 263, 1,0,0, 4033, 1, 1,  1);
      vecs[8]  = mk(100, 200, 101, 264, 1,0,0, 4033, 0, 0,  1);
      vecs[9]  = mk(100, 200, 105, 203, 0,0,0, 4033, 0, 0,  0);
      vecs[10] = mk(100, 200, 100, 200, 1,1,0, 63,   1, 15, 1);

      repeat (3) @(posedge Clk);
      #1;
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_pal_index", int'(pal_index), 0);
      chk("rst_sprite_on", int'(sprite_on), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_anim_frame", int'(anim_frame), 0);
      Reset_n = 1'b1;
      step();

      foreach (vecs[i]) begin
         facing_left = vecs[i].face;
         tick();
         spr_x = vecs[i].sx; spr_y = vecs[i].sy; DrawX = vecs[i].x; DrawY = vecs[i].y;
         pix_valid = vecs[i].v; rom_zero = vecs[i].zero;
         step();
         chk($sformatf("vec%0d_rom_addr", i), int'(rom_addr), int'(vecs[i].addr));
         pix_valid = 1'b0;
         step(); step();
         chk($sformatf("vec%0d_sprite_on", i), int'(sprite_on), int'(vecs[i].on));
         chk($sformatf("vec%0d_pal_index", i), int'(pal_index), int'(vecs[i].idx));
         chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vecs[i].ov));
         rom_zero = 1'b0;
      end

      // full animation; extra punch during PLAY must not extend or restart it
      facing_left = 1'b0;
      punch_edge();
      chk("pend_no_busy_yet", int'(busy), 0);
      for (int k = 1; k <= 30; k++) begin
         tick();
         ef = (k <= 6) ? 0 : (k <= 12) ? 1 : (k <= 26) ? 2 : 0;
         eb = (k <= 26) ? 1 : 0;
         chk($sformatf("anim_frame_k%0d", k), int'(anim_frame), ef);
         chk($sformatf("busy_k%0d", k), int'(busy), eb);
         if (k == 3) punch_edge();
         if (k == 7) begin
            pixel(0, 0, 0, 0);
            chk("frame1_rom_addr", int'(rom_addr), 4096);
            pix_valid = 1'b0;
            step(); step();
            chk("frame1_pal_index", int'(pal_index), 1);
         end
      end

      // punch edge coincident with vsync in IDLE: start waits for the next tick
      punch_req = 1'b1; vsync_tick = 1'b1; step();
      vsync_tick = 1'b0; step();
      chk("coinc_not_started", int'(busy), 0);
      tick();
      chk("coinc_started_busy", int'(busy), 1);
      chk("coinc_started_frame", int'(anim_frame), 0);
      repeat (12) tick();
      chk("pre_reset_frame", int'(anim_frame), 2);
      pixel(0, 0, 5, 0);
      pix_valid = 1'b0;
      step(); step();
      chk("pre_reset_sprite_on", int'(sprite_on), 1);
      chk("pre_reset_pal_index", int'(pal_index), 7);
      #1 Reset_n = 1'b0;
      #1;
      chk("async_rst_frame", int'(anim_frame), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_sprite_on", int'(sprite_on), 0);
      chk("async_rst_pal_index", int'(pal_index), 0);
      repeat (3) step();
      Reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("held_punch_no_restart_%0d", k), int'(busy), 0);
      end
      punch_req = 1'b0; step();
      punch_req = 1'b1; step();
      tick();
      chk("fresh_edge_restart", int'(busy), 1);
      punch_req = 1'b0;

      // continuous raster: out_valid is pix_valid delayed exactly three cycles
      pat = 32'hB38F_1C65;
      spr_x = 10'd0; spr_y = 10'd0; DrawY = 10'd10;
      for (int i = 0; i < 35; i++) begin
         if (i >= 3) chk($sformatf("raster_out_valid_%0d", i), int'(out_valid), int'(pat[i-3]));
         pix_valid = (i < 32) ? pat[i] : 1'b0;
         DrawX = 10'(i);
         step();
      end

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
